// File: rtl/elevator_ctrl.sv
// Four-floor SCAN elevator scheduler: latches floor calls, moves one floor per
// MOVE_CYCLES and holds the door open for DOOR_CYCLES at each served floor.
module elevator_ctrl #(
   parameter int MOVE_CYCLES = 4,
   parameter int DOOR_CYCLES = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] call_req,
   output logic [1:0] floorSel,
   output logic       door,
   output logic       moving_up,
   output logic       moving_down,
   output logic [3:0] pending
);

   localparam int MaxCycles = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
   localparam int TimerW    = $clog2(MaxCycles + 1);
   localparam logic [TimerW-1:0] MoveLoad = TimerW'(MOVE_CYCLES - 1);
   localparam logic [TimerW-1:0] DoorLoad = TimerW'(DOOR_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      MOVE_UP,
      MOVE_DOWN,
      DOOR_OPEN
   } stateT;

   stateT             state;
   logic [TimerW-1:0] timer;
   logic              dirUp;

   logic       above;
   logic       below;
   logic       beyondUp;
   logic       beyondDown;
   logic [1:0] nxtUp;
   logic [1:0] nxtDown;
   logic [3:0] reqSet;
   logic [3:0] curMask;
   logic [3:0] upMask;
   logic [3:0] downMask;

   // Request geometry relative to the car and to the floor it is about to reach.
   always_comb begin
      above      = 1'b0;
      below      = 1'b0;
      beyondUp   = 1'b0;
      beyondDown = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > int'(floorSel))     above      = above      | pending[i];
         if (i < int'(floorSel))     below      = below      | pending[i];
         if (i > int'(floorSel) + 1) beyondUp   = beyondUp   | pending[i];
         if (i < int'(floorSel) - 1) beyondDown = beyondDown | pending[i];
      end
      nxtUp    = floorSel + 2'd1;
      nxtDown  = floorSel - 2'd1;
      reqSet   = pending | call_req;
      curMask  = 4'b0001 << floorSel;
      upMask   = 4'b0001 << nxtUp;
      downMask = 4'b0001 << nxtDown;
   end

   // Clearing a floor's bit on the same edge it is requested drops that request.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         floorSel    <= 2'd0;
         door        <= 1'b0;
         moving_up   <= 1'b0;
         moving_down <= 1'b0;
         pending     <= 4'b0000;
         dirUp       <= 1'b1;
         timer       <= '0;
      end else begin
         pending <= reqSet;
         case (state)
            IDLE: begin
               if (pending[floorSel]) begin
                  state   <= DOOR_OPEN;
                  door    <= 1'b1;
                  timer   <= DoorLoad;
                  pending <= reqSet & ~curMask;
               end else if (above && (dirUp || !below)) begin
                  state     <= MOVE_UP;
                  dirUp     <= 1'b1;
                  moving_up <= 1'b1;
                  timer     <= MoveLoad;
               end else if (below) begin
                  state       <= MOVE_DOWN;
                  dirUp       <= 1'b0;
                  moving_down <= 1'b1;
                  timer       <= MoveLoad;
               end
            end
            MOVE_UP: begin
               if (floorSel == 2'd3) begin
                  state     <= IDLE;
                  moving_up <= 1'b0;
               end else if (timer != '0) begin
                  timer <= timer - 1'b1;
               end else begin
                  floorSel <= nxtUp;
                  if (pending[nxtUp]) begin
                     state     <= DOOR_OPEN;
                     moving_up <= 1'b0;
                     door      <= 1'b1;
                     timer     <= DoorLoad;
                     pending   <= reqSet & ~upMask;
                  end else if (beyondUp) begin
                     timer <= MoveLoad;
                  end else begin
                     state     <= IDLE;
                     moving_up <= 1'b0;
                  end
               end
            end
            MOVE_DOWN: begin
               if (floorSel == 2'd0) begin
                  state       <= IDLE;
                  moving_down <= 1'b0;
               end else if (timer != '0) begin
                  timer <= timer - 1'b1;
               end else begin
                  floorSel <= nxtDown;
                  if (pending[nxtDown]) begin
                     state       <= DOOR_OPEN;
                     moving_down <= 1'b0;
                     door        <= 1'b1;
                     timer       <= DoorLoad;
                     pending     <= reqSet & ~downMask;
                  end else if (beyondDown) begin
                     timer <= MoveLoad;
                  end else begin
                     state       <= IDLE;
                     moving_down <= 1'b0;
                  end
               end
            end
            DOOR_OPEN: begin
               // A call for this floor while the door is open just keeps it open longer.
               pending <= reqSet & ~curMask;
               if (call_req[floorSel]) begin
                  timer <= DoorLoad;
               end else if (timer == '0) begin
                  state <= IDLE;
                  door  <= 1'b0;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               door        <= 1'b0;
               moving_up   <= 1'b0;
               moving_down <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl with hand-computed, edge-by-edge expectations
// using the default MOVE_CYCLES=4, DOOR_CYCLES=3.
module tb_elevator_ctrl;

   logic       clk;
   logic       rst_n;
   logic [3:0] call_req;
   logic [1:0] floorSel;
   logic       door;
   logic       moving_up;
   logic       moving_down;
   logic [3:0] pending;

   int numCompared;
   int numMismatched;

   elevator_ctrl #(.MOVE_CYCLES(4), .DOOR_CYCLES(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .call_req   (call_req),
      .floorSel   (floorSel),
      .door       (door),
      .moving_up  (moving_up),
      .moving_down(moving_down),
      .pending    (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every step lands 1 time unit after a rising edge, where inputs change and outputs are read.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      numCompared++;
      if (observed !== expected) begin
         numMismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic checkCar(input string tag, input logic [1:0] expFloor, input logic expDoor,
                           input logic expUp, input logic expDown, input logic [3:0] expPend);
      checkOutput({tag, ".floor"},   8'(floorSel),    8'(expFloor));
      checkOutput({tag, ".door"},    8'(door),        8'(expDoor));
      checkOutput({tag, ".up"},      8'(moving_up),   8'(expUp));
      checkOutput({tag, ".down"},    8'(moving_down), 8'(expDown));
      checkOutput({tag, ".pending"}, 8'(pending),     8'(expPend));
   endtask

   // Presents a call for exactly one sampling edge (the next one).
   task automatic applyStimulus(input logic [3:0] req);
      call_req = req;
      tick();
      call_req = 4'b0000;
   endtask

   task automatic doReset();
      rst_n    = 1'b0;
      call_req = 4'b0000;
      tick(2);
      rst_n = 1'b1;
   endtask

   initial begin
      numCompared   = 0;
      numMismatched = 0;
      rst_n         = 1'b0;
      call_req      = 4'b0000;

      // Reset holds everything cleared even with calls present
      call_req = 4'b1111;
      tick(2);
      checkCar("reset", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
      call_req = 4'b0000;
      rst_n    = 1'b1;
      tick();
      checkCar("reset.release", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);

      // Same-floor call: door open for edges 2..4, closed at 5
      doReset();
      applyStimulus(4'b0001);
      checkCar("same.e1", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0001);
      tick();
      checkCar("same.e2", 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000);
      tick(2);
      checkCar("same.e4", 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000);
      tick();
      checkCar("same.e5", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);

      // Floor 0 -> 2 timing: edges 1/2/6/10/13
      doReset();
      applyStimulus(4'b0100);
      checkCar("trip.e1", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0100);
      tick();
      checkCar("trip.e2", 2'd0, 1'b0, 1'b1, 1'b0, 4'b0100);
      tick(3);
      checkCar("trip.e5", 2'd0, 1'b0, 1'b1, 1'b0, 4'b0100);
      tick();
      checkCar("trip.e6", 2'd1, 1'b0, 1'b1, 1'b0, 4'b0100);
      tick(3);
      checkCar("trip.e9", 2'd1, 1'b0, 1'b1, 1'b0, 4'b0100);
      tick();
      checkCar("trip.e10", 2'd2, 1'b1, 1'b0, 1'b0, 4'b0000);
      tick(2);
      checkCar("trip.e12", 2'd2, 1'b1, 1'b0, 1'b0, 4'b0000);
      tick();
      checkCar("trip.e13", 2'd2, 1'b0, 1'b0, 1'b0, 4'b0000);

      // SCAN: serve 1 and 3 going up before turning back for 0
      doReset();
      applyStimulus(4'b1000);
      tick();
      checkCar("scan.e2", 2'd0, 1'b0, 1'b1, 1'b0, 4'b1000);
      applyStimulus(4'b0011);
      checkCar("scan.e3", 2'd0, 1'b0, 1'b1, 1'b0, 4'b1011);
      tick(3);
      checkCar("scan.e6", 2'd1, 1'b1, 1'b0, 1'b0, 4'b1001);
      tick(3);
      checkCar("scan.e9", 2'd1, 1'b0, 1'b0, 1'b0, 4'b1001);
      tick();
      checkCar("scan.e10", 2'd1, 1'b0, 1'b1, 1'b0, 4'b1001);
      tick(4);
      checkCar("scan.e14", 2'd2, 1'b0, 1'b1, 1'b0, 4'b1001);
      tick(4);
      checkCar("scan.e18", 2'd3, 1'b1, 1'b0, 1'b0, 4'b0001);
      tick(3);
      checkCar("scan.e21", 2'd3, 1'b0, 1'b0, 1'b0, 4'b0001);
      tick();
      checkCar("scan.e22", 2'd3, 1'b0, 1'b0, 1'b1, 4'b0001);
      tick(4);
      checkCar("scan.e26", 2'd2, 1'b0, 1'b0, 1'b1, 4'b0001);
      tick(4);
      checkCar("scan.e30", 2'd1, 1'b0, 1'b0, 1'b1, 4'b0001);
      tick(4);
      checkCar("scan.e34", 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000);
      tick(3);
      checkCar("scan.e37", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);

      // Door absorb: re-call floor 2 at edge 12 keeps door open through edge 14
      doReset();
      applyStimulus(4'b0100);
      tick(9);
      checkCar("absorb.e10", 2'd2, 1'b1, 1'b0, 1'b0, 4'b0000);
      tick();
      applyStimulus(4'b0100);
      checkCar("absorb.e12", 2'd2, 1'b1, 1'b0, 1'b0, 4'b0000);
      tick();
      checkCar("absorb.e13", 2'd2, 1'b1, 1'b0, 1'b0, 4'b0000);
      tick();
      checkCar("absorb.e14", 2'd2, 1'b1, 1'b0, 1'b0, 4'b0000);
      tick();
      checkCar("absorb.e15", 2'd2, 1'b0, 1'b0, 1'b0, 4'b0000);

      // Reset mid-move aborts the trip and drops all requests
      doReset();
      applyStimulus(4'b1000);
      tick(5);
      checkCar("abort.e6", 2'd1, 1'b0, 1'b1, 1'b0, 4'b1000);
      rst_n    = 1'b0;
      call_req = 4'b0010;
      tick();
      checkCar("abort.rst", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
      rst_n    = 1'b1;
      call_req = 4'b0000;
      tick(2);
      checkCar("abort.after", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
